i2c_temp_responder: RTL and testbench
=====================================

// Module: i2c_temp_responder
// PURPOSE
//  I2C target (slave) model of the board temperature sensor, oversampling SCL/SDA on clk_200kHz.
//  Acknowledges its 7-bit address on a read and returns a 16-bit temperature word as MSB then LSB.
//  Serves two roles: simulation partner for the sensor-read master, and an FPGA-side sensor emulator.
//  SDA is open-drain: the block only ever pulls the line low or releases it.
// PARAMETERS
//  DEV_ADDR     7'h4B  7-bit target address; read header byte is {DEV_ADDR,1'b1} = 8'h97
//  SYNC_STAGES  2      input synchroniser depth on scl_in/sda_in, 2..3
// PORTS
//  clk_200kHz    in   1   system clock; all state changes on its rising edge
//  reset_n       in   1   asynchronous, active-low reset
//  scl_in        in   1   I2C SCL line level; asynchronous to clk_200kHz
//  sda_in        in   1   I2C SDA line level; asynchronous to clk_200kHz
//  temp_word     in   16  temperature register contents; {MSB,LSB}; MSB[6:0]:LSB[7] = deg C
//  sda_pull_low  out  1   1 = drive SDA to 0, 0 = release (high-Z); the only SDA driver
//  busy          out  1   high from START until STOP or an end-of-transfer return to IDLE
//  addr_match    out  1   one-cycle pulse when the address is ACKed
//  read_done     out  1   one-cycle pulse when the master NACKs a data byte
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, shift register 0, bit counter 0, snapshot 0.
//    reset_n low mid-transfer releases SDA immediately, asynchronously.
//  Line conditioning:
//    scl_s/sda_s = SYNC_STAGES-flop synchronised inputs; prior-cycle copies give the edge detectors.
//    scl_rise/scl_fall are single-cycle pulses.
//    START = sda_s falls while scl_s==1 and scl_s is stable; STOP = sda_s rises while scl_s==1.
//  States:
//    IDLE -> ADDR on START.
//    ADDR: shift sda_s in MSB-first on each scl_rise; after the 8th rise, go to ADDR_ACK on the next scl_fall.
//    ADDR_ACK:
//      Taken only if byte == {DEV_ADDR,1}: pull low one cycle after entry; latch snapshot <= temp_word;
//        pulse addr_match; byte_sel = 0.
//      Address mismatch or R/W=0: do not pull low (NACK) and go to WAIT_STOP.
//      Release SDA on the next scl_fall, then enter TX.
//    TX: on entry and on each subsequent scl_fall, drive snapshot bit (byte_sel ? LSB : MSB), MSB-first.
//      sda_pull_low = ~bit. Each bit is updated within 1 clk of scl_fall, well inside the 10-clk SCL low phase.
//      After the 8th bit's scl_fall, release SDA and go to RX_ACK.
//    RX_ACK: sample sda_s on scl_rise.
//      0 (ACK): toggle byte_sel (MSB->LSB->MSB wrap) and return to TX on scl_fall.
//      1 (NACK): pulse read_done and go to WAIT_STOP.
//    WAIT_STOP: SDA released; STOP -> IDLE; START -> ADDR.
//  Global priority: STOP > START > bit activity.
//    START in any state (repeated start) releases SDA within 1 clk and goes to ADDR with the bit counter cleared.
//    STOP in any state releases SDA and goes to IDLE.
//  Snapshot: captured once per address match. temp_word changes during a read never affect in-flight bytes.
//  Master omits STOP and issues a repeated START after NACK: must work (handled by the global START rule).
//  Width rules: bit counter 3 bits, wraps 7->0 at byte end. No arithmetic on temp_word.
// STRUCTURE
//  Package i2c_pkg: state enum (IDLE, ADDR, ADDR_ACK, TX, RX_ACK, WAIT_STOP), I2C_RD/I2C_WR
//    constants, default sensor address 7'h4B.
//  Sub-module i2c_line_sync: synchronisers plus scl_rise/scl_fall/start/stop pulse outputs.
//    The top holds the FSM, shift/bit counter, snapshot and output registers.
// TESTING
//  Clocking: 10 kHz SCL, 20 clk_200kHz per SCL period.
//  1 Read header 0x97, temp_word=16'h0C80, master ACK after MSB, NACK after LSB:
//      SDA low in the 9th SCL clock; bytes 0x0C then 0x80 on SDA; read_done pulses once; SDA released; busy=0 after STOP.
//  2 Header 0x91 (address 0x48): sda_pull_low stays 0 for the whole transfer; addr_match never pulses.
//  3 Header 0x96 (write to 0x4B): no ACK; WAIT_STOP; next 0x97 read is answered normally.
//  4 Master ACKs after LSB with temp_word=16'h1980: third byte on SDA = 0x19 (wrap); NACK then ends the read.
//  5 temp_word 0x0C80 -> 0x7FF0 one SCL period after the address ACK: bytes sent are 0x0C, 0x80;
//      the next read returns 0x7F, 0xF0.
//  6 Repeated START injected at bit 3 of the MSB byte while SDA is pulled low: release within 1 clk
//      of START detection, re-ACK 0x97; then reset_n low mid-TX: sda_pull_low=0 with no clock edge.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C temperature-sensor target model.
package i2c_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      ADDR_ACK,
      TX,
      RX_ACK,
      WAIT_STOP
   } state_t;

   localparam logic       I2C_RD      = 1'b1;
   localparam logic       I2C_WR      = 1'b0;
   localparam logic [6:0] SENSOR_ADDR = 7'h4B;

endpackage

// File: rtl/i2c_line_sync.sv
// SCL/SDA synchronisers with single-cycle edge and START/STOP condition pulses.
module i2c_line_sync #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk_200kHz,
   input  logic reset_n,
   input  logic scl_in,
   input  logic sda_in,
   output logic sda_s,
   output logic scl_rise,
   output logic scl_fall,
   output logic start,
   output logic stop
);

   logic [SYNC_STAGES-1:0] scl_sync;
   logic [SYNC_STAGES-1:0] sda_sync;
   logic                   scl_s;
   logic                   scl_d;
   logic                   sda_d;

   // Synchronisers reset to the idle-bus level so release of reset cannot fake a START.
   always_ff @(posedge clk_200kHz or negedge reset_n) begin
      if (!reset_n) begin
         scl_sync <= '1;
         sda_sync <= '1;
         scl_d    <= 1'b1;
         sda_d    <= 1'b1;
      end else begin
         scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
         sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
         scl_d    <= scl_s;
         sda_d    <= sda_s;
      end
   end

   always_comb begin
      scl_s    = scl_sync[SYNC_STAGES-1];
      sda_s    = sda_sync[SYNC_STAGES-1];
      scl_rise = scl_s & ~scl_d;
      scl_fall = ~scl_s & scl_d;
      start    = scl_s & scl_d & sda_d & ~sda_s;
      stop     = scl_s & scl_d & ~sda_d & sda_s;
   end

endmodule

// File: rtl/i2c_temp_responder.sv
// I2C read-only target answering its address with a 16-bit temperature word, MSB first.
module i2c_temp_responder
   import i2c_pkg::*;
#(
   parameter logic [6:0]  DEV_ADDR    = SENSOR_ADDR,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic        clk_200kHz,
   input  logic        reset_n,
   input  logic        scl_in,
   input  logic        sda_in,
   input  logic [15:0] temp_word,
   output logic        sda_pull_low,
   output logic        busy,
   output logic        addr_match,
   output logic        read_done
);

   logic sda_s;
   logic scl_rise;
   logic scl_fall;
   logic start;
   logic stop;

   i2c_line_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_line_sync (
      .clk_200kHz (clk_200kHz),
      .reset_n    (reset_n),
      .scl_in     (scl_in),
      .sda_in     (sda_in),
      .sda_s      (sda_s),
      .scl_rise   (scl_rise),
      .scl_fall   (scl_fall),
      .start      (start),
      .stop       (stop)
   );

   state_t      state, state_nxt;
   logic [7:0]  shift, shift_nxt;
   logic [2:0]  bit_cnt, bit_cnt_nxt;
   logic        have_byte, have_byte_nxt;
   logic [15:0] snapshot, snapshot_nxt;
   logic        byte_sel, byte_sel_nxt;
   logic        pull_nxt;
   logic        busy_nxt;
   logic        addr_match_nxt;
   logic        read_done_nxt;
   logic [7:0]  tx_byte;
   logic [2:0]  bit_idx;

   always_ff @(posedge clk_200kHz or negedge reset_n) begin
      if (!reset_n) begin
         state        <= IDLE;
         shift        <= '0;
         bit_cnt      <= '0;
         have_byte    <= 1'b0;
         snapshot     <= '0;
         byte_sel     <= 1'b0;
         sda_pull_low <= 1'b0;
         busy         <= 1'b0;
         addr_match   <= 1'b0;
         read_done    <= 1'b0;
      end else begin
         state        <= state_nxt;
         shift        <= shift_nxt;
         bit_cnt      <= bit_cnt_nxt;
         have_byte    <= have_byte_nxt;
         snapshot     <= snapshot_nxt;
         byte_sel     <= byte_sel_nxt;
         sda_pull_low <= pull_nxt;
         busy         <= busy_nxt;
         addr_match   <= addr_match_nxt;
         read_done    <= read_done_nxt;
      end
   end

   always_comb begin
      state_nxt      = state;
      shift_nxt      = shift;
      bit_cnt_nxt    = bit_cnt;
      have_byte_nxt  = have_byte;
      snapshot_nxt   = snapshot;
      byte_sel_nxt   = byte_sel;
      pull_nxt       = sda_pull_low;
      addr_match_nxt = 1'b0;
      read_done_nxt  = 1'b0;
      tx_byte        = byte_sel ? snapshot[7:0] : snapshot[15:8];
      bit_idx        = 3'd7 - bit_cnt;

      if (stop) begin
         state_nxt     = IDLE;
         pull_nxt      = 1'b0;
         bit_cnt_nxt   = '0;
         have_byte_nxt = 1'b0;
      end else if (start) begin
         state_nxt     = ADDR;
         pull_nxt      = 1'b0;
         bit_cnt_nxt   = '0;
         have_byte_nxt = 1'b0;
         shift_nxt     = '0;
      end else begin
         unique case (state)
            IDLE: ;
            ADDR: begin
               if (scl_rise) begin
                  shift_nxt   = {shift[6:0], sda_s};
                  bit_cnt_nxt = bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) have_byte_nxt = 1'b1;
               end else if (scl_fall && have_byte) begin
                  have_byte_nxt = 1'b0;
                  if (shift[7:1] == DEV_ADDR && shift[0] != I2C_WR) state_nxt = ADDR_ACK;
                  else                                               state_nxt = WAIT_STOP;
               end
            end
            // ACK is driven the cycle after entry; the following SCL fall hands over straight to bit 7.
            ADDR_ACK: begin
               if (scl_fall) begin
                  state_nxt   = TX;
                  pull_nxt    = ~tx_byte[7];
                  bit_cnt_nxt = 3'd1;
               end else if (!sda_pull_low) begin
                  pull_nxt       = 1'b1;
                  snapshot_nxt   = temp_word;
                  addr_match_nxt = 1'b1;
                  byte_sel_nxt   = 1'b0;
               end
            end
            // bit_cnt counts bits already placed on SDA; wrapping to 0 marks the byte end.
            TX: begin
               if (scl_fall) begin
                  if (bit_cnt == 3'd0) begin
                     pull_nxt  = 1'b0;
                     state_nxt = RX_ACK;
                  end else begin
                     pull_nxt    = ~tx_byte[bit_idx];
                     bit_cnt_nxt = bit_cnt + 3'd1;
                  end
               end
            end
            RX_ACK: begin
               if (scl_rise) begin
                  if (!sda_s) begin
                     byte_sel_nxt = ~byte_sel;
                  end else begin
                     read_done_nxt = 1'b1;
                     state_nxt     = WAIT_STOP;
                  end
               end else if (scl_fall) begin
                  state_nxt   = TX;
                  pull_nxt    = ~tx_byte[7];
                  bit_cnt_nxt = 3'd1;
               end
            end
            WAIT_STOP: pull_nxt = 1'b0;
            default: begin
               state_nxt = IDLE;
               pull_nxt  = 1'b0;
            end
         endcase
      end

      busy_nxt = (state_nxt != IDLE);
   end

endmodule

// File: tb/tb_i2c_temp_responder.sv
// Directed bench: a bit-banged I2C master reads the temperature target and checks the replies.
module tb_i2c_temp_responder;

   logic        clk_200kHz = 1'b0;
   logic        reset_n;
   logic        scl_in;
   logic        m_sda;
   logic        force_mode;
   logic        sda_in;
   logic [15:0] temp_word;
   logic        sda_pull_low;
   logic        busy;
   logic        addr_match;
   logic        read_done;

   int n_checks = 0;
   int n_fail   = 0;
   int rd_cnt   = 0;
   int am_cnt   = 0;
   int pull_cnt = 0;

   // Wired-AND bus; force_mode lets the master override the target to inject a START.
   assign sda_in = force_mode ? m_sda : (m_sda & ~sda_pull_low);

   i2c_temp_responder #(
      .DEV_ADDR    (7'h4B),
      .SYNC_STAGES (2)
   ) dut (
      .clk_200kHz   (clk_200kHz),
      .reset_n      (reset_n),
      .scl_in       (scl_in),
      .sda_in       (sda_in),
      .temp_word    (temp_word),
      .sda_pull_low (sda_pull_low),
      .busy         (busy),
      .addr_match   (addr_match),
      .read_done    (read_done)
   );

   always #5 clk_200kHz = ~clk_200kHz;

   always @(posedge clk_200kHz) begin
      if (read_done)    rd_cnt++;
      if (addr_match)   am_cnt++;
      if (sda_pull_low) pull_cnt++;
   end

   task automatic clks(input int n);
      repeat (n) @(negedge clk_200kHz);
   endtask

   task automatic clear_counts();
      rd_cnt   = 0;
      am_cnt   = 0;
      pull_cnt = 0;
   endtask

   // One SCL period of 20 clocks: data changes mid-low, sampled mid-high, ends with SCL low.
   task automatic bit_slot(input logic b, output logic s);
      clks(5);
      m_sda = b;
      clks(5);
      scl_in = 1'b1;
      clks(5);
      s = sda_in;
      clks(5);
      scl_in = 1'b0;
   endtask

   task automatic start_cond();
      m_sda = 1'b1;
      clks(5);
      scl_in = 1'b1;
      clks(10);
      m_sda = 1'b0;
      clks(10);
      scl_in = 1'b0;
   endtask

   task automatic stop_cond();
      clks(5);
      m_sda = 1'b0;
      clks(5);
      scl_in = 1'b1;
      clks(10);
      m_sda = 1'b1;
      clks(10);
   endtask

   task automatic send_byte(input logic [7:0] b, output logic ack);
      logic s;
      for (int i = 7; i >= 0; i--) bit_slot(b[i], s);
      bit_slot(1'b1, ack);
   endtask

   task automatic recv_byte(input logic ack_bit, output logic [7:0] d);
      logic s;
      for (int i = 7; i >= 0; i--) begin
         bit_slot(1'b1, s);
         d[i] = s;
      end
      bit_slot(ack_bit, s);
   endtask

   task automatic test_reset();
      n_checks++;
      if ({sda_pull_low, busy, addr_match, read_done} !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_outputs: got %b expected 0000", {sda_pull_low, busy, addr_match, read_done});
      end
   endtask

   task automatic test_basic_read();
      logic       ack;
      logic [7:0] d0, d1;
      clear_counts();
      temp_word = 16'h0C80;
      start_cond();
      send_byte(8'h97, ack);
      n_checks++;
      if (ack !== 1'b0) begin n_fail++; $display("FAIL t1_addr_ack: got %b expected 0", ack); end
      n_checks++;
      if (busy !== 1'b1) begin n_fail++; $display("FAIL t1_busy_mid: got %b expected 1", busy); end
      recv_byte(1'b0, d0);
      recv_byte(1'b1, d1);
      stop_cond();
      n_checks++;
      if (d0 !== 8'h0C) begin n_fail++; $display("FAIL t1_msb: got %h expected 0c", d0); end
      n_checks++;
      if (d1 !== 8'h80) begin n_fail++; $display("FAIL t1_lsb: got %h expected 80", d1); end
      n_checks++;
      if (rd_cnt !== 1) begin n_fail++; $display("FAIL t1_read_done_count: got %0d expected 1", rd_cnt); end
      n_checks++;
      if (am_cnt !== 1) begin n_fail++; $display("FAIL t1_addr_match_count: got %0d expected 1", am_cnt); end
      n_checks++;
      if ({busy, sda_pull_low} !== 2'b00) begin
         n_fail++;
         $display("FAIL t1_after_stop: got busy,pull=%b expected 00", {busy, sda_pull_low});
      end
   endtask

   task automatic test_wrong_addr();
      logic       ack;
      logic [7:0] d;
      clear_counts();
      start_cond();
      send_byte(8'h91, ack);
      recv_byte(1'b1, d);
      stop_cond();
      n_checks++;
      if (ack !== 1'b1) begin n_fail++; $display("FAIL t2_nack: got %b expected 1", ack); end
      n_checks++;
      if (d !== 8'hFF) begin n_fail++; $display("FAIL t2_bus_idle: got %h expected ff", d); end
      n_checks++;
      if (pull_cnt !== 0) begin n_fail++; $display("FAIL t2_pull_cycles: got %0d expected 0", pull_cnt); end
      n_checks++;
      if (am_cnt !== 0) begin n_fail++; $display("FAIL t2_addr_match_count: got %0d expected 0", am_cnt); end
   endtask

   task automatic test_write_header();
      logic       ack;
      logic [7:0] d0, d1;
      clear_counts();
      start_cond();
      send_byte(8'h96, ack);
      n_checks++;
      if (ack !== 1'b1) begin n_fail++; $display("FAIL t3_write_nack: got %b expected 1", ack); end
      n_checks++;
      if (busy !== 1'b1) begin n_fail++; $display("FAIL t3_wait_stop_busy: got %b expected 1", busy); end
      stop_cond();
      n_checks++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL t3_idle: got %b expected 0", busy); end
      start_cond();
      send_byte(8'h97, ack);
      recv_byte(1'b0, d0);
      recv_byte(1'b1, d1);
      stop_cond();
      n_checks++;
      if (ack !== 1'b0) begin n_fail++; $display("FAIL t3_read_ack: got %b expected 0", ack); end
      n_checks++;
      if ({d0, d1} !== 16'h0C80) begin n_fail++; $display("FAIL t3_read_word: got %h expected 0c80", {d0, d1}); end
      n_checks++;
      if (am_cnt !== 1) begin n_fail++; $display("FAIL t3_addr_match_count: got %0d expected 1", am_cnt); end
   endtask

   task automatic test_wrap();
      logic       ack;
      logic [7:0] d0, d1, d2;
      clear_counts();
      temp_word = 16'h1980;
      start_cond();
      send_byte(8'h97, ack);
      recv_byte(1'b0, d0);
      recv_byte(1'b0, d1);
      recv_byte(1'b1, d2);
      stop_cond();
      n_checks++;
      if ({d0, d1} !== 16'h1980) begin n_fail++; $display("FAIL t4_first_word: got %h expected 1980", {d0, d1}); end
      n_checks++;
      if (d2 !== 8'h19) begin n_fail++; $display("FAIL t4_wrap_byte: got %h expected 19", d2); end
      n_checks++;
      if (rd_cnt !== 1) begin n_fail++; $display("FAIL t4_read_done_count: got %0d expected 1", rd_cnt); end
   endtask

   task automatic test_snapshot();
      logic       ack;
      logic [7:0] d0, d1;
      temp_word = 16'h0C80;
      start_cond();
      send_byte(8'h97, ack);
      fork
         begin
            clks(20);
            temp_word = 16'h7FF0;
         end
         begin
            recv_byte(1'b0, d0);
            recv_byte(1'b1, d1);
         end
      join
      stop_cond();
      n_checks++;
      if ({d0, d1} !== 16'h0C80) begin n_fail++; $display("FAIL t5_in_flight: got %h expected 0c80", {d0, d1}); end
      start_cond();
      send_byte(8'h97, ack);
      recv_byte(1'b0, d0);
      recv_byte(1'b1, d1);
      stop_cond();
      n_checks++;
      if ({d0, d1} !== 16'h7FF0) begin n_fail++; $display("FAIL t5_next_read: got %h expected 7ff0", {d0, d1}); end
   endtask

   task automatic test_restart_and_reset();
      logic       ack;
      logic       s;
      logic [7:0] d0, d1;
      clear_counts();
      temp_word = 16'h0C80;
      start_cond();
      send_byte(8'h97, ack);
      for (int i = 0; i < 3; i++) bit_slot(1'b1, s);
      // Fourth MSB bit is 0, so the target is pulling low when the START is forced.
      clks(5);
      n_checks++;
      if (sda_pull_low !== 1'b1) begin n_fail++; $display("FAIL t6_pull_before_start: got %b expected 1", sda_pull_low); end
      force_mode = 1'b1;
      m_sda = 1'b1;
      clks(5);
      scl_in = 1'b1;
      clks(5);
      m_sda = 1'b0;
      repeat (3) @(posedge clk_200kHz);
      #1;
      n_checks++;
      if (sda_pull_low !== 1'b0) begin n_fail++; $display("FAIL t6_restart_release: got %b expected 0", sda_pull_low); end
      n_checks++;
      if (busy !== 1'b1) begin n_fail++; $display("FAIL t6_restart_busy: got %b expected 1", busy); end
      force_mode = 1'b0;
      clks(5);
      scl_in = 1'b0;
      send_byte(8'h97, ack);
      n_checks++;
      if (ack !== 1'b0) begin n_fail++; $display("FAIL t6_reack: got %b expected 0", ack); end
      n_checks++;
      if (am_cnt !== 2) begin n_fail++; $display("FAIL t6_addr_match_count: got %0d expected 2", am_cnt); end
      clks(5);
      n_checks++;
      if (sda_pull_low !== 1'b1) begin n_fail++; $display("FAIL t6_pull_mid_tx: got %b expected 1", sda_pull_low); end
      @(posedge clk_200kHz);
      #1;
      reset_n = 1'b0;
      #1;
      n_checks++;
      if ({sda_pull_low, busy} !== 2'b00) begin
         n_fail++;
         $display("FAIL t6_async_reset: got pull,busy=%b expected 00", {sda_pull_low, busy});
      end
      scl_in = 1'b1;
      m_sda  = 1'b1;
      clks(5);
      reset_n = 1'b1;
      clks(5);
      start_cond();
      send_byte(8'h97, ack);
      recv_byte(1'b0, d0);
      recv_byte(1'b1, d1);
      stop_cond();
      n_checks++;
      if ({ack, d0, d1} !== {1'b0, 16'h0C80}) begin
         n_fail++;
         $display("FAIL t6_after_reset_read: got ack=%b word=%h expected ack=0 word=0c80", ack, {d0, d1});
      end
   endtask

   initial begin
      reset_n    = 1'b0;
      scl_in     = 1'b1;
      m_sda      = 1'b1;
      force_mode = 1'b0;
      temp_word  = 16'h0C80;
      clks(3);
      test_reset();
      reset_n = 1'b1;
      clks(5);
      test_basic_read();
      test_wrong_addr();
      test_write_header();
      test_wrap();
      test_snapshot();
      test_restart_and_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
